// File: rtl/hex_scan_display_if.sv
// Bundle between the datapath (master) and the scanned hex display driver (slave).
// The datapath supplies the value and display options. The driver returns the board pin levels.
interface hex_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank_lz;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [6:0]              seg;

  modport master (
    output load,
    output value,
    output blank_lz,
    output blink_en,
    input  digit_sel,
    input  seg
  );

  modport slave (
    input  load,
    input  value,
    input  blank_lz,
    input  blink_en,
    output digit_sel,
    output seg
  );
endinterface

// File: rtl/hex_scan_display.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment hex digits on one shared, active-low segment bus.
// Optional features are leading-zero blanking and whole-display blink.
module hex_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLINK_DIV  = 250
) (
  input  logic               clk,
  input  logic               reset,
  hex_scan_display_if.slave  bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0:    f = 7'b1000000;
      4'h1:    f = 7'b1111001;
      4'h2:    f = 7'b0100100;
      4'h3:    f = 7'b0110000;
      4'h4:    f = 7'b0011001;
      4'h5:    f = 7'b0010010;
      4'h6:    f = 7'b0000010;
      4'h7:    f = 7'b1111000;
      4'h8:    f = 7'b0000000;
      4'h9:    f = 7'b0010000;
      4'hA:    f = 7'b0001000;
      4'hB:    f = 7'b0000011;
      4'hC:    f = 7'b1000110;
      4'hD:    f = 7'b0100001;
      4'hE:    f = 7'b0000110;
      4'hF:    f = 7'b0001110;
      default: f = 7'b1111111;
    endcase
    return f;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    tick_s;
  logic [NUM_DIGITS-1:0]   lz_zero_s;
  logic [NUM_DIGITS-1:0]   onehot_n_s;
  logic                    blank_s;
  logic [3:0]              nib_s;
  logic                    all_zero_s;

  assign tick_s = (pre_q == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= {(4*NUM_DIGITS){1'b0}};
      pre_q    <= {PW{1'b0}};
      idx_q    <= {IW{1'b0}};
      bcnt_q   <= {BW{1'b0}};
      phase_q  <= 1'b0;
      seg_q    <= 7'h7F;
      sel_q    <= {NUM_DIGITS{1'b1}};
    end else begin
      shadow_q <= shadow_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    if (bus.load) begin
      shadow_d = bus.value;
    end else begin
      shadow_d = shadow_q;
    end
    if (tick_s) begin
      pre_d = {PW{1'b0}};
      if (idx_q == IDX_MAX) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
    end
    // Blink state only advances on scan ticks and is parked at the visible phase while disabled
    if (!bus.blink_en) begin
      bcnt_d  = {BW{1'b0}};
      phase_d = 1'b0;
    end else if (tick_s) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = {BW{1'b0}};
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
    end
  end

  always_comb begin
    all_zero_s = 1'b1;
    lz_zero_s  = {NUM_DIGITS{1'b0}};
    onehot_n_s = {NUM_DIGITS{1'b1}};
    // lz_zero_s[i] is set when nibbles i up to the top are all zero
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero_s   = all_zero_s & (shadow_q[4*i +: 4] == 4'h0);
      lz_zero_s[i] = all_zero_s;
      onehot_n_s[i] = (idx_q == IW'(i)) ? 1'b0 : 1'b1;
    end
    nib_s   = shadow_q[{idx_q, 2'b00} +: 4];
    blank_s = bus.blank_lz && (idx_q != {IW{1'b0}}) && lz_zero_s[idx_q];
    if (bus.blink_en && phase_q) begin
      seg_d = 7'h7F;
      sel_d = {NUM_DIGITS{1'b1}};
    end else if (blank_s) begin
      seg_d = 7'h7F;
      sel_d = onehot_n_s;
    end else begin
      seg_d = font(nib_s);
      sel_d = onehot_n_s;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display (4 digits, CLK_DIV=4, BLINK_DIV=2).
// The driver queues expected pin levels per cycle and a monitor pops and compares them.
module tb_hex_scan_display;

  typedef struct {
    int         cyc;
    int         tid;
    logic [6:0] seg;
    logic [3:0] sel;
  } exp_t;

  localparam logic [27:0] TBL0    = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [27:0] TBLA    = {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110};
  localparam logic [27:0] TBLB    = {7'b1111111, 7'b1111111, 7'b0000011, 7'b1000000};
  localparam logic [27:0] TBLZ    = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [27:0] TBL1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] TBL4444 = {7'b0011001, 7'b0011001, 7'b0011001, 7'b0011001};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   tid = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];

  hex_scan_display_if #(.NUM_DIGITS(4)) bus ();

  hex_scan_display #(
    .NUM_DIGITS(4),
    .CLK_DIV(4),
    .BLINK_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int n, input logic [6:0] s, input logic [3:0] d);
    exp_t e;
    e.cyc = n;
    e.tid = tid;
    e.seg = s;
    e.sel = d;
    q.push_back(e);
  endtask

  task automatic expect_scan(input int n0, input int n1, input logic [27:0] tbl);
    for (int n = n0; n <= n1; n++) begin
      int d;
      d = ((n - base) / 4) % 4;
      push(n, tbl[7*d +: 7], ~(4'b0001 << d));
    end
  endtask

  task automatic push_blank(input int n0, input int n1);
    for (int n = n0; n <= n1; n++) push(n, 7'h7F, 4'hF);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.load  = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // monitor: checks at each falling edge and also right after an asynchronous reset
  initial begin
    forever begin
      @(negedge clk or posedge reset);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (e.cyc != cyc || bus.seg !== e.seg || bus.digit_sel !== e.sel) begin
          n_fail++;
          $display("FAIL test%0d cyc=%0d (due %0d): seg=%b sel=%b, required seg=%b sel=%b",
                   e.tid, cyc, e.cyc, bus.seg, bus.digit_sel, e.seg, e.sel);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete, %0d expectations pending", q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int c;
    int e;
    int s;
    int t;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;

    tid = 1;
    @(negedge clk);
    c = cyc;
    push_blank(c + 1, c + 2);
    wait_cyc(c + 2);
    reset = 1'b0;
    base = cyc + 1;
    expect_scan(base, base + 16, TBL0);
    wait_cyc(base + 16);

    tid = 2;
    c = cyc;
    expect_scan(c + 1, c + 1, TBL0);
    expect_scan(c + 2, c + 17, TBLA);
    pulse_load(16'h1A2F);
    wait_cyc(c + 17);

    tid = 3;
    c = cyc;
    bus.blank_lz = 1'b1;
    expect_scan(c + 2, c + 17, TBLB);
    pulse_load(16'h00B0);
    wait_cyc(c + 17);

    tid = 4;
    c = cyc;
    expect_scan(c + 2, c + 17, TBLZ);
    pulse_load(16'h0000);
    wait_cyc(c + 17);

    tid = 5;
    c = cyc;
    bus.blank_lz = 1'b0;
    e = c + 4;
    while ((e + 1 - base) % 4 != 0) e++;
    expect_scan(c + 2, e, TBL1234);
    pulse_load(16'h1234);
    wait_cyc(e);
    bus.blink_en = 1'b1;
    s = e + 1;
    expect_scan(s, s + 7, TBL1234);
    push_blank(s + 8, s + 15);
    expect_scan(s + 16, s + 23, TBL1234);
    push_blank(s + 24, s + 27);
    wait_cyc(s + 27);
    bus.blink_en = 1'b0;
    expect_scan(s + 28, s + 31, TBL1234);
    wait_cyc(s + 31);

    tid = 6;
    c = cyc;
    t = c + 1;
    while ((t - base) % 4 != 2) t++;
    expect_scan(c + 1, t + 1, TBL1234);
    wait_cyc(t);
    expect_scan(t + 2, t + 9, TBL4444);
    pulse_load(16'h4444);
    wait_cyc(t + 9);

    tid = 7;
    c = cyc;
    e = c + 1;
    while ((e + 1 - base) % 16 != 0) e++;
    expect_scan(c + 1, e, TBL4444);
    wait_cyc(e);
    bus.blink_en = 1'b1;
    s = e + 1;
    expect_scan(s, s + 7, TBL4444);
    push_blank(s + 8, s + 8);
    wait_cyc(s + 8);
    #2;
    push(cyc, 7'h7F, 4'hF);
    reset = 1'b1;
    push_blank(s + 9, s + 10);
    wait_cyc(s + 10);
    reset = 1'b0;
    base = cyc + 1;
    expect_scan(base, base + 7, TBL0);
    push_blank(base + 8, base + 15);
    wait_cyc(base + 15);
    bus.blink_en = 1'b0;
    expect_scan(base + 16, base + 17, TBL0);
    wait_cyc(base + 17);

    tid = 8;
    #2;
    push(cyc, 7'h7F, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expectations never checked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
